scan_display: RTL and testbench

Parametrised multiplexed decimal display driver for the EDA front panel. It captures two binary channel values and converts each to `DIGITS` BCD digits with a sequential double-dabble converter. It then time-multiplexes all `2*DIGITS` digits onto one shared 4-bit digit bus with one-hot digit selects. It adds leading-zero blanking, per-channel blink, overflow saturation and a programmable scan rate, and sits between the counter/controller logic and the board's BCD-to-7-segment decoder.

---
 rtl/scan_display_pkg.sv | 22 ++
 rtl/bin2bcd_seq.sv | 76 +++++++
 rtl/scan_display.sv | 191 +++++++++++++++++++
 tb/tb_scan_display.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_display_pkg.sv
// Shared types and helpers for the multiplexed decimal display driver.
package scan_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_A = 2'd1,
    CONV_B = 2'd2,
    COMMIT = 2'd3
  } conv_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_NINE = 4'd9;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one shift/add-3 iteration per clock.
// The start cycle performs the first iteration, so done pulses W cycles after start.
module bin2bcd_seq
  import scan_display_pkg::*;
#(
  parameter int W      = 20,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(W + 1);
  localparam int DW = 4 * DIGITS;

  logic [W-1:0]  sh_q, sh_d;
  logic [DW-1:0] bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [W-1:0]  it_sh, step_sh;
  logic [DW-1:0] it_bcd, adj, step_bcd;
  bcd_t          nib;

  always_comb begin
    it_sh  = start ? bin : sh_q;
    it_bcd = start ? '0 : bcd_q;
    adj    = it_bcd;
    nib    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = adj[4*i +: 4];
      if (nib >= 4'd5) adj[4*i +: 4] = nib + 4'd3;
    end
    // Carry out of the top nibble is dropped: only DIGITS digits are kept.
    step_bcd = {adj[DW-2:0], it_sh[W-1]};
    step_sh  = it_sh << 1;

    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      sh_d   = step_sh;
      bcd_d  = step_bcd;
      cnt_d  = CW'(W - 1);
      done_d = (W == 1);
    end else if (cnt_q != '0) begin
      sh_d   = step_sh;
      bcd_d  = step_bcd;
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/scan_display.sv
// Two-channel binary-to-decimal display driver: shared sequential converter,
// one-hot digit scan with leading-zero blanking, blink and overflow saturation.
module scan_display
  import scan_display_pkg::*;
#(
  parameter int W              = 20,
  parameter int DIGITS         = 2,
  parameter int SCAN_DIV       = 1,
  parameter int BLINK_DIV      = 64,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          value_a,
  input  logic [W-1:0]          value_b,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [1:0]            blink,
  output logic [2*DIGITS-1:0]   dig,
  output logic [3:0]            num,
  output logic                  busy,
  output logic [1:0]            ovf,
  output conv_state_e           state_dbg
);

  localparam int N  = 2 * DIGITS;
  localparam int SW = $clog2(N);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int DW = 4 * DIGITS;
  localparam longint unsigned OVF_LIM = pow10(DIGITS);
  localparam logic [N-1:0]  DIG_OFF   = DIG_ACTIVE_LOW ? '1 : '0;
  localparam logic [DW-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

  conv_state_e   state_q, state_d;
  logic [W-1:0]  cap_b_q, cap_b_d;
  logic [1:0]    ovf_pend_q, ovf_pend_d;
  logic [DW-1:0] bcd_a_q, bcd_a_d;
  logic [DW-1:0] disp_a_q, disp_a_d;
  logic [DW-1:0] disp_b_q, disp_b_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          busy_q, busy_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [N-1:0]  dig_q, dig_d;
  logic [3:0]    num_q, num_d;

  logic          conv_start, conv_done;
  logic [W-1:0]  conv_bin;
  logic [DW-1:0] conv_bcd;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    state_d    = state_q;
    cap_b_d    = cap_b_q;
    ovf_pend_d = ovf_pend_q;
    bcd_a_d    = bcd_a_q;
    disp_a_d   = disp_a_q;
    disp_b_d   = disp_b_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    conv_start = 1'b0;
    conv_bin   = cap_b_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d    = CONV_A;
          cap_b_d    = value_b;
          ovf_pend_d = {64'(value_b) >= OVF_LIM, 64'(value_a) >= OVF_LIM};
          busy_d     = 1'b1;
          conv_start = 1'b1;
          conv_bin   = value_a;
        end
      end
      CONV_A: begin
        // Channel A result is parked while the converter is reused for B.
        if (conv_done) begin
          bcd_a_d    = conv_bcd;
          conv_start = 1'b1;
          state_d    = CONV_B;
        end
      end
      CONV_B: begin
        if (conv_done) state_d = COMMIT;
      end
      COMMIT: begin
        disp_a_d = ovf_pend_q[0] ? ALL_NINES : bcd_a_q;
        disp_b_d = ovf_pend_q[1] ? ALL_NINES : conv_bcd;
        ovf_d    = ovf_pend_q;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic          tc, ch_b, upper_zero, suppress;
  logic [SW-1:0] di;
  logic [DW-1:0] disp_sel;
  bcd_t          nib;

  always_comb begin
    presc_d  = presc_q;
    slot_d   = slot_q;
    frame_d  = frame_q;
    phase_d  = phase_q;
    dig_d    = dig_q;
    num_d    = num_q;
    tc       = (presc_q == PW'(SCAN_DIV - 1));
    ch_b     = (slot_q >= SW'(DIGITS));
    di       = ch_b ? (slot_q - SW'(DIGITS)) : slot_q;
    disp_sel = ch_b ? disp_b_q : disp_a_q;
    nib      = disp_sel[{di, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (SW'(j) >= di && disp_sel[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    suppress = (blank_lz && di != '0 && upper_zero) || (blink[ch_b] && phase_q);

    if (tc) begin
      presc_d = '0;
      dig_d   = (suppress ? '0 : (N'(1) << slot_q)) ^ DIG_OFF;
      num_d   = suppress ? 4'd0 : nib;
      if (slot_q == SW'(N - 1)) begin
        slot_d = '0;
        if (frame_q == FW'(BLINK_DIV - 1)) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cap_b_q    <= '0;
      ovf_pend_q <= '0;
      bcd_a_q    <= '0;
      disp_a_q   <= '0;
      disp_b_q   <= '0;
      ovf_q      <= '0;
      busy_q     <= 1'b0;
      presc_q    <= '0;
      slot_q     <= '0;
      frame_q    <= '0;
      phase_q    <= 1'b0;
      dig_q      <= DIG_OFF;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      cap_b_q    <= cap_b_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_a_q    <= bcd_a_d;
      disp_a_q   <= disp_a_d;
      disp_b_q   <= disp_b_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      presc_q    <= presc_d;
      slot_q     <= slot_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      dig_q      <= dig_d;
      num_q      <= num_d;
    end
  end

  assign dig       = dig_q;
  assign num       = num_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_scan_display.sv
// Bench for scan_display: directed scenarios plus randomized loads, all cycles
// compared against a decimal-arithmetic model of the display.
module tb_scan_display;
  import scan_display_pkg::*;

  localparam int W         = 20;
  localparam int DIGITS    = 2;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int N         = 2 * DIGITS;
  localparam int LIM       = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  value_a = '0;
  logic [W-1:0]  value_b = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic [1:0]    blink = 2'b00;
  logic [N-1:0]  dig;
  logic [3:0]    num;
  logic          busy;
  logic [1:0]    ovf;
  conv_state_e   state_dbg;

  int tests = 0;
  int fails = 0;

  scan_display #(
    .W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
    .BLINK_DIV(BLINK_DIV), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .value_a(value_a), .value_b(value_b),
    .load(load), .blank_lz(blank_lz), .blink(blink),
    .dig(dig), .num(num), .busy(busy), .ovf(ovf), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: tracks time since reset, the accepted load and the
  // decimal value each channel displays.
  int          n_edges = 0;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  int unsigned m_va = 0, m_vb = 0, m_da = 0, m_db = 0;
  logic [1:0]  m_ovf = 2'b00;
  logic [N-1:0] exp_dig = '0;
  logic [3:0]  exp_num = '0;
  int          m_k, m_s, m_ch, m_di;
  int unsigned m_v, m_digit;
  bit          m_sup;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_edges = 0; m_busy = 1'b0; m_cnt = 0;
      m_da = 0; m_db = 0; m_ovf = 2'b00;
      exp_dig = '0; exp_num = '0;
    end else begin
      n_edges++;
      if (n_edges % SCAN_DIV == 0) begin
        m_k  = n_edges / SCAN_DIV - 1;
        m_s  = m_k % N;
        m_ch = m_s / DIGITS;
        m_di = m_s % DIGITS;
        m_v  = (m_ch == 1) ? m_db : m_da;
        m_digit = (m_v / (10 ** m_di)) % 10;
        m_sup = (blank_lz && m_di > 0 && (m_v / (10 ** m_di)) == 0) ||
                (blink[m_ch] && ((m_k / (N * BLINK_DIV)) % 2 == 1));
        exp_dig = '0;
        exp_num = 4'd0;
        if (!m_sup) begin
          exp_dig[m_s] = 1'b1;
          exp_num = 4'(m_digit);
        end
      end
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 2 * W + 1) begin
          m_busy = 1'b0;
          m_ovf  = {m_vb >= LIM, m_va >= LIM};
          m_da   = (m_va >= LIM) ? LIM - 1 : m_va;
          m_db   = (m_vb >= LIM) ? LIM - 1 : m_vb;
        end
      end else if (load) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_va   = value_a;
        m_vb   = value_b;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_all();
    check("dig", 32'(dig), 32'(exp_dig));
    check("num", 32'(num), 32'(exp_num));
    check("busy", 32'(busy), 32'(m_busy));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_load(input logic [W-1:0] a, input logic [W-1:0] b);
    value_a = a;
    value_b = b;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  logic [N-1:0] fr_seen;
  logic [3:0]   fr_num [N];
  int           fr_len [N];

  task automatic capture_frame();
    fr_seen = '0;
    for (int s = 0; s < N; s++) begin
      fr_num[s] = 4'd0;
      fr_len[s] = 0;
    end
    run(SCAN_DIV);
    repeat (N * SCAN_DIV) begin
      tick();
      for (int s = 0; s < N; s++) begin
        if (dig[s]) begin
          fr_seen[s] = 1'b1;
          fr_num[s]  = num;
          fr_len[s]++;
        end
      end
    end
  endtask

  task automatic count_active(input int n, output int a_cnt, output int b_cnt);
    a_cnt = 0;
    b_cnt = 0;
    repeat (n) begin
      tick();
      if (dig[DIGITS-1:0] != '0) a_cnt++;
      if (dig[N-1:DIGITS] != '0) b_cnt++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, a_cnt, b_cnt;
    logic [W-1:0] ra, rb;
    int hold;

    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_dig", 32'(dig), 32'd0);
    check("reset_num", 32'(num), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));

    // 37 / 5, no blanking: latency and scan order
    start_load(20'd37, 20'd5);
    wait_idle(cyc);
    check("latency", 32'(cyc), 32'd41);
    capture_frame();
    check("f1_seen", 32'(fr_seen), 32'hF);
    check("f1_d0", 32'(fr_num[0]), 32'd7);
    check("f1_d1", 32'(fr_num[1]), 32'd3);
    check("f1_d2", 32'(fr_num[2]), 32'd5);
    check("f1_d3", 32'(fr_num[3]), 32'd0);
    check("f1_slot_len", 32'(fr_len[0]), 32'd4);

    // 5 / 0 with leading-zero blanking
    blank_lz = 1'b1;
    start_load(20'd5, 20'd0);
    wait_idle(cyc);
    capture_frame();
    check("lz_seen", 32'(fr_seen), 32'b0101);
    check("lz_d0", 32'(fr_num[0]), 32'd5);
    check("lz_d2", 32'(fr_num[2]), 32'd0);

    // Overflow saturation
    blank_lz = 1'b0;
    start_load(20'd123, 20'd99);
    wait_idle(cyc);
    check("ovf_flag", 32'(ovf), 32'b01);
    capture_frame();
    check("ovf_seen", 32'(fr_seen), 32'hF);
    for (int s = 0; s < N; s++) check("ovf_digit", 32'(fr_num[s]), 32'd9);

    // Load during busy is ignored
    start_load(20'd11, 20'd22);
    run(9);
    value_a = 20'd88;
    value_b = 20'd77;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_idle(cyc);
    check("ignored_latency", 32'(cyc + 10), 32'd41);
    capture_frame();
    check("ign_d0", 32'(fr_num[0]), 32'd1);
    check("ign_d1", 32'(fr_num[1]), 32'd1);
    check("ign_d2", 32'(fr_num[2]), 32'd2);
    check("ign_d3", 32'(fr_num[3]), 32'd2);

    // Blink channel B: on half the time, channel A untouched
    blink = 2'b10;
    run(SCAN_DIV);
    count_active(4 * N * BLINK_DIV * SCAN_DIV, a_cnt, b_cnt);
    check("blink_a_cycles", 32'(a_cnt), 32'd64);
    check("blink_b_cycles", 32'(b_cnt), 32'd32);
    blink = 2'b00;

    // Reset mid-conversion
    start_load(20'd55, 20'd66);
    run(19);
    rst = 1'b1;
    #1;
    check("rst_dig", 32'(dig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    capture_frame();
    check("rst_seen", 32'(fr_seen), 32'hF);
    for (int s = 0; s < N; s++) check("rst_digit", 32'(fr_num[s]), 32'd0);
    start_load(20'd42, 20'd0);
    wait_idle(cyc);
    capture_frame();
    check("post_rst_d0", 32'(fr_num[0]), 32'd2);
    check("post_rst_d1", 32'(fr_num[1]), 32'd4);

    // Randomized loads against the model
    for (int it = 0; it < 30; it++) begin
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, (1 << W) - 1)) : W'($urandom_range(0, 120));
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, (1 << W) - 1)) : W'($urandom_range(0, 120));
      blank_lz = 1'($urandom_range(0, 1));
      blink = 2'($urandom_range(0, 3));
      hold = $urandom_range(0, 4);
      value_a = ra;
      value_b = rb;
      load = 1'b1;
      tick();
      if (hold != 0) load = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        run($urandom_range(1, 30));
        value_a = W'($urandom_range(0, 120));
        load = 1'b1;
        tick();
        load = 1'b0;
      end
      wait_idle(cyc);
      check("rand_idle", 32'(busy), 32'd0);
      if (hold == 0) begin
        tick();
        load = 1'b0;
        wait_idle(cyc);
      end
      run($urandom_range(0, 40));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
